// File: rtl/dac_step_scheduler_pkg.sv
// Shared types and constants for the DAC step scheduler: FSM encoding,
// request source selection and CV code width.
package dac_sched_pkg;

    localparam int         CV_W    = 12;
    localparam logic [7:0] OVR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SRC_SAVE,
        SRC_PREV,
        SRC_STEP
    } src_t;

endpackage

// File: rtl/dac_step_scheduler_if.sv
// Link between the step scheduler and the I2C DAC controller: request side
// (data, enable, writeToMem) and the controller's status (SCL_t, data_reg).
interface dac_step_scheduler_if;
    import dac_sched_pkg::*;

    logic [CV_W-1:0] dac_data;
    logic            dac_enable;
    logic            dac_write_mem;
    logic            dac_scl_t;
    logic [CV_W-1:0] dac_data_reg;

    modport master (
        output dac_data, dac_enable, dac_write_mem,
        input  dac_scl_t, dac_data_reg
    );

    modport slave (
        input  dac_data, dac_enable, dac_write_mem,
        output dac_scl_t, dac_data_reg
    );

endinterface

// File: rtl/dac_step_scheduler_cv_step_table.sv
// Per-step CV register file: synchronous write, asynchronous read.
// Out-of-range addresses are ignored on write and read back as zero.
module cv_step_table
    import dac_sched_pkg::*;
#(
    parameter int NUM_STEPS = 16,
    parameter int STEP_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [STEP_W-1:0] wr_addr,
    input  logic [CV_W-1:0]   wr_data,
    input  logic [STEP_W-1:0] rd_addr,
    output logic [CV_W-1:0]   rd_data
);

    logic [CV_W-1:0] mem [NUM_STEPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) mem[i] <= '0;
        end else if (wr_en && (int'(wr_addr) < NUM_STEPS)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (int'(rd_addr) < NUM_STEPS) ? mem[rd_addr] : '0;

endmodule

// File: rtl/dac_step_scheduler.sv
// Step sequencer DAC front end: steps through the CV table, merges step,
// preview and EEPROM-save requests and runs one controller transaction at a time.
module dac_step_scheduler
    import dac_sched_pkg::*;
#(
    parameter int NUM_STEPS     = 16,
    parameter int STEP_W        = 4,
    parameter int START_TIMEOUT = 4095
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                step_tick,
    input  logic                tbl_wr_en,
    input  logic [STEP_W-1:0]   tbl_wr_addr,
    input  logic [CV_W-1:0]     tbl_wr_data,
    input  logic                preview_req,
    input  logic [CV_W-1:0]     preview_data,
    input  logic                save_req,
    dac_step_scheduler_if.master dac,
    output logic [STEP_W-1:0]   cur_step,
    output logic                busy,
    output logic                timeout_err,
    output logic [7:0]          overrun_cnt
);

    localparam int TO_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

    state_t            state, state_nx;
    src_t              grant_src;
    logic              run_q, run_fall, step_adv;
    logic              step_pend, prev_pend, save_pend;
    logic              clr_step, clr_prev, clr_save;
    logic              load_data, to_expire, op_save;
    logic [CV_W-1:0]   preview_buf, tbl_rd, grant_code;
    logic [TO_W-1:0]   to_cnt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == OVR_MAX) ? v : v + 8'd1;
    endfunction

    cv_step_table #(.NUM_STEPS(NUM_STEPS), .STEP_W(STEP_W)) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tbl_wr_en),
        .wr_addr (tbl_wr_addr),
        .wr_data (tbl_wr_data),
        .rd_addr (cur_step),
        .rd_data (tbl_rd)
    );

    assign run_fall = run_q & ~run;
    assign step_adv = step_tick & run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Grant picks save > preview > step; an update equal to the controller's
    // last value is retired without touching the bus.
    always_comb begin
        state_nx   = state;
        grant_src  = SRC_STEP;
        grant_code = tbl_rd;
        clr_save   = 1'b0;
        clr_prev   = 1'b0;
        clr_step   = 1'b0;
        load_data  = 1'b0;
        to_expire  = 1'b0;
        case (state)
            IDLE: begin
                if (save_pend) begin
                    clr_save  = 1'b1;
                    grant_src = SRC_SAVE;
                    state_nx  = ISSUE;
                end else if (prev_pend) begin
                    clr_prev   = 1'b1;
                    grant_src  = SRC_PREV;
                    grant_code = preview_buf;
                    if (preview_buf != dac.dac_data_reg) begin
                        load_data = 1'b1;
                        state_nx  = ISSUE;
                    end
                end else if (step_pend) begin
                    clr_step = 1'b1;
                    if (tbl_rd != dac.dac_data_reg) begin
                        load_data = 1'b1;
                        state_nx  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!dac.dac_scl_t) begin
                    state_nx = WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    to_expire = 1'b1;
                    state_nx  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (dac.dac_scl_t) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q       <= 1'b0;
            cur_step    <= '0;
            step_pend   <= 1'b0;
            prev_pend   <= 1'b0;
            save_pend   <= 1'b0;
            preview_buf <= '0;
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
            op_save     <= 1'b0;
            to_cnt      <= '0;
            dac.dac_data <= '0;
        end else begin
            run_q <= run;
            if (run_fall) begin
                cur_step  <= '0;
                step_pend <= 1'b0;
            end else begin
                if (step_adv) begin
                    if (int'(cur_step) == NUM_STEPS - 1) cur_step <= '0;
                    else                                  cur_step <= cur_step + 1'b1;
                end
                step_pend <= step_adv | (step_pend & ~clr_step);
            end
            if (step_adv && step_pend) overrun_cnt <= sat_inc(overrun_cnt);

            prev_pend <= preview_req | (prev_pend & ~clr_prev);
            save_pend <= save_req | (save_pend & ~clr_save);
            if (preview_req) preview_buf <= preview_data;

            if (state == IDLE && state_nx == ISSUE) op_save <= (grant_src == SRC_SAVE);
            if (load_data) dac.dac_data <= grant_code;

            to_cnt <= (state == ISSUE) ? to_cnt + 1'b1 : '0;
            if (to_expire) timeout_err <= 1'b1;
        end
    end

    assign busy              = (state != IDLE);
    assign dac.dac_enable    = (state == ISSUE) && !op_save;
    assign dac.dac_write_mem = (state == ISSUE) && op_save;

endmodule

// File: tb/tb_dac_step_scheduler.sv
// Directed bench for dac_step_scheduler with a small I2C DAC controller model
// that claims SCL a few cycles after a request and releases it later.
module tb_dac_step_scheduler;
    import dac_sched_pkg::*;

    localparam int CLAIM_DLY = 5;
    localparam int HOLD      = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step_tick = 1'b0;
    logic        tbl_wr_en = 1'b0;
    logic [1:0]  tbl_wr_addr = '0;
    logic [11:0] tbl_wr_data = '0;
    logic        preview_req = 1'b0;
    logic [11:0] preview_data = '0;
    logic        save_req = 1'b0;
    logic [1:0]  cur_step;
    logic        busy, timeout_err;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int errors = 0;
    int m_phase, m_cnt;
    bit never_claim = 1'b0;

    dac_step_scheduler_if dac_if ();

    dac_step_scheduler #(.NUM_STEPS(4), .STEP_W(2), .START_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .step_tick    (step_tick),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_wr_addr  (tbl_wr_addr),
        .tbl_wr_data  (tbl_wr_data),
        .preview_req  (preview_req),
        .preview_data (preview_data),
        .save_req     (save_req),
        .dac          (dac_if.master),
        .cur_step     (cur_step),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    // Controller model: claims SCL after CLAIM_DLY cycles, latches the sent
    // value on an update, releases SCL HOLD cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_cnt   <= 0;
            dac_if.dac_scl_t    <= 1'b1;
            dac_if.dac_data_reg <= '0;
        end else begin
            case (m_phase)
                0: if ((dac_if.dac_enable || dac_if.dac_write_mem) && !never_claim) begin
                    m_phase <= 1;
                    m_cnt   <= 1;
                end
                1: if (m_cnt == CLAIM_DLY) begin
                    dac_if.dac_scl_t <= 1'b0;
                    if (dac_if.dac_enable) dac_if.dac_data_reg <= dac_if.dac_data;
                    m_phase <= 2;
                    m_cnt   <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                default: if (m_cnt == HOLD - 1) begin
                    dac_if.dac_scl_t <= 1'b1;
                    m_phase <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_tbl(input logic [1:0] a, input logic [11:0] d);
        tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_data = d;
        @(negedge clk);
        tbl_wr_en = 1'b0;
    endtask

    task automatic tick();
        step_tick = 1'b1;
        @(negedge clk);
        step_tick = 1'b0;
    endtask

    task automatic preview(input logic [11:0] d);
        preview_req = 1'b1; preview_data = d;
        @(negedge clk);
        preview_req = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!(dac_if.dac_enable || dac_if.dac_write_mem) && n < 200) begin
            @(negedge clk); n++;
        end
        chk({tag, " req seen"}, 32'(n < 200), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk); n++;
        end
        chk({tag, " idle"}, 32'(n < 200), 32'd1);
    endtask

    task automatic wait_claim(input string tag);
        int n = 0;
        while (dac_if.dac_scl_t && n < 100) begin
            @(negedge clk); n++;
        end
        chk({tag, " claim"}, 32'(n < 100), 32'd1);
        @(negedge clk);
    endtask

    task automatic quiet(input string tag, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            seen |= busy | dac_if.dac_enable | dac_if.dac_write_mem;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [11:0] seq_exp [4];
        int n;
        seq_exp = '{12'h200, 12'h300, 12'h400, 12'h100};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst dac_data", 32'(dac_if.dac_data), 32'h0);
        chk("rst enable", 32'(dac_if.dac_enable), 32'h0);
        chk("rst write_mem", 32'(dac_if.dac_write_mem), 32'h0);
        chk("rst cur_step", 32'(cur_step), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst timeout", 32'(timeout_err), 32'h0);
        chk("rst overrun", 32'(overrun_cnt), 32'h0);

        // Step sequence with wrap and two-cycle request latency
        wr_tbl(2'd0, 12'h100);
        wr_tbl(2'd1, 12'h200);
        wr_tbl(2'd2, 12'h300);
        wr_tbl(2'd3, 12'h400);
        run = 1'b1;
        @(negedge clk);
        tick();
        chk("lat1 enable", 32'(dac_if.dac_enable), 32'h0);
        @(negedge clk);
        chk("lat2 enable", 32'(dac_if.dac_enable), 32'h1);
        chk("seq0 data", 32'(dac_if.dac_data), 32'(seq_exp[0]));
        chk("seq0 step", 32'(cur_step), 32'd1);
        wait_idle("seq0");
        for (int i = 1; i < 4; i++) begin
            tick();
            wait_req("seq");
            chk($sformatf("seq%0d data", i), 32'(dac_if.dac_data), 32'(seq_exp[i]));
            chk($sformatf("seq%0d step", i), 32'(cur_step), 32'((i + 1) % 4));
            wait_idle("seq");
        end

        // Equal-value skip: load 0x200 into the controller, then step onto table[1]=0x200
        preview(12'h200);
        wait_req("pv200");
        wait_idle("pv200");
        tick();
        quiet("skip no transaction", 10);
        chk("skip step", 32'(cur_step), 32'd1);
        chk("skip data held", 32'(dac_if.dac_data), 32'h200);

        // Simultaneous save, preview and step: served in priority order
        save_req = 1'b1; preview_req = 1'b1; preview_data = 12'h7FF; step_tick = 1'b1;
        @(negedge clk);
        save_req = 1'b0; preview_req = 1'b0; step_tick = 1'b0;
        wait_req("pri save");
        chk("pri save write_mem", 32'(dac_if.dac_write_mem), 32'h1);
        chk("pri save enable", 32'(dac_if.dac_enable), 32'h0);
        chk("pri save data", 32'(dac_if.dac_data), 32'h200);
        wait_idle("pri save");
        wait_req("pri prev");
        chk("pri prev enable", 32'(dac_if.dac_enable), 32'h1);
        chk("pri prev data", 32'(dac_if.dac_data), 32'h7FF);
        wait_idle("pri prev");
        wait_req("pri step");
        chk("pri step data", 32'(dac_if.dac_data), 32'h300);
        chk("pri step idx", 32'(cur_step), 32'd2);
        wait_idle("pri step");

        // Overrun: three ticks while WAIT_DONE, only the last step is sent
        preview(12'h055);
        wait_req("ovr");
        wait_claim("ovr");
        tick(); tick(); tick();
        chk("ovr count", 32'(overrun_cnt), 32'd2);
        chk("ovr step", 32'(cur_step), 32'd1);
        chk("ovr busy", 32'(busy), 32'd1);
        chk("ovr data held", 32'(dac_if.dac_data), 32'h055);
        wait_idle("ovr");
        wait_req("ovr step");
        chk("ovr step data", 32'(dac_if.dac_data), 32'h200);
        wait_idle("ovr step");
        quiet("ovr single issue", 10);

        // Start timeout: controller never claims the bus
        never_claim = 1'b1;
        preview(12'h123);
        wait_req("to");
        n = 0;
        while (dac_if.dac_enable && n < 100) begin
            n++; @(negedge clk);
        end
        chk("to enable cycles", 32'(n), 32'd15);
        chk("to err", 32'(timeout_err), 32'd1);
        chk("to busy", 32'(busy), 32'd0);
        never_claim = 1'b0;
        preview(12'h456);
        wait_req("to next");
        chk("to next data", 32'(dac_if.dac_data), 32'h456);
        wait_idle("to next");
        chk("to err sticky", 32'(timeout_err), 32'd1);

        // Asynchronous reset in WAIT_DONE
        preview(12'h321);
        wait_req("rst mid");
        wait_claim("rst mid");
        chk("pre-rst busy", 32'(busy), 32'd1);
        chk("pre-rst data", 32'(dac_if.dac_data), 32'h321);
        #2 rst = 1'b1;
        #1;
        chk("arst dac_data", 32'(dac_if.dac_data), 32'h0);
        chk("arst busy", 32'(busy), 32'h0);
        chk("arst timeout", 32'(timeout_err), 32'h0);
        chk("arst overrun", 32'(overrun_cnt), 32'h0);
        chk("arst enable", 32'(dac_if.dac_enable | dac_if.dac_write_mem), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("post-rst step", 32'(cur_step), 32'd0);
        tick();
        quiet("post-rst table zero", 10);
        chk("post-rst step adv", 32'(cur_step), 32'd1);

        // Run falling edge clears the step index; ticks while stopped are ignored
        run = 1'b0;
        @(negedge clk);
        chk("run fall step", 32'(cur_step), 32'd0);
        wr_tbl(2'd1, 12'hABC);
        tick();
        chk("stopped tick step", 32'(cur_step), 32'd0);
        quiet("stopped tick idle", 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
